// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters (req0: execute
//   stage, req1: address/PC path). Round-robin arbitration, one transaction
//   at a time: IDLE (arbitrate, latch operands) -> EXEC (capture aluOut)
//   -> DONE (done pulse to the owner) -> IDLE.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   req0/req1            level requests, held until done is seen
//   op0/op1              ALUOp code: 00 add, 01 sub, 10 mul, 11 compare
//   a0/a1, b0/b1         operands
//   gnt0/gnt1            one-cycle pulse: request accepted, operands latched
//   done0/done1          one-cycle pulse: result/ltFlag valid
//   result               last captured ALU result, held until next capture
//   ltFlag               signed SrcA<SrcB from the last compare (op 11)
//   ltClear              clear request for ltFlag and the ALU lt register
//   ALUOp, SrcA, SrcB    registered drive to the ALU
//   ltRegReset           clear strobe to the ALU lt register
//   aluOut               combinational ALU output

module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             ltFlag,
  input  logic             ltClear,
  output logic [1:0]       ALUOp,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic             ltRegReset,
  input  logic [WIDTH-1:0] aluOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   owner;        // 0: req0 owns the transaction in flight, 1: req1
  logic   prio;         // requester that wins a simultaneous request
  logic   clr_pending;  // ltClear seen during EXEC, applied in DONE

  logic   win_valid;
  logic   win_sel;

  always_comb begin
    win_valid = req0 | req1;
    // Single request wins outright; on a tie the priority pointer decides.
    win_sel   = (req0 & req1) ? prio : req1;
  end

  // The ALU lt register must not be cleared while the compare is being
  // evaluated, so a clear arriving in EXEC is held and issued in DONE.
  always_comb begin
    ltRegReset = reset | ((ltClear | clr_pending) & (state != EXEC));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      result      <= '0;
      ltFlag      <= 1'b0;
      ALUOp       <= 2'b00;
      SrcA        <= '0;
      SrcB        <= '0;
      owner       <= 1'b0;
      prio        <= RR_INIT;
      clr_pending <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (ltClear) begin
            ltFlag <= 1'b0;
          end
          if (win_valid) begin
            owner <= win_sel;
            prio  <= ~win_sel;
            ALUOp <= win_sel ? op1 : op0;
            SrcA  <= win_sel ? a1 : a0;
            SrcB  <= win_sel ? b1 : b0;
            gnt0  <= ~win_sel;
            gnt1  <= win_sel;
            state <= EXEC;
          end else begin
            // Keep the ALU on add so it never performs a spurious compare.
            ALUOp <= 2'b00;
          end
        end
        EXEC: begin
          result <= aluOut;
          if (ALUOp == 2'b11) begin
            ltFlag <= aluOut[WIDTH-1];
          end
          if (ltClear) begin
            clr_pending <= 1'b1;
          end
          // done is registered here so the pulse lines up with the DONE cycle.
          done0 <= ~owner;
          done1 <= owner;
          state <= DONE;
        end
        DONE: begin
          ALUOp <= 2'b00;
          // A deferred clear lands after any compare capture from EXEC.
          if (ltClear | clr_pending) begin
            ltFlag <= 1'b0;
          end
          clr_pending <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter. A small combinational ALU stand-in
//   drives aluOut; each task runs one scenario and checks inline.

module tb_alu_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [W-1:0] a0, a1, b0, b1;
  logic         gnt0, gnt1, done0, done1;
  logic [W-1:0] result;
  logic         ltFlag;
  logic         ltClear;
  logic [1:0]   ALUOp;
  logic [W-1:0] SrcA, SrcB;
  logic         ltRegReset;
  logic [W-1:0] aluOut;
  logic [31:0]  prod;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: add, sub, mul (low half), compare (sub).
  always_comb begin
    prod = 32'(SrcA) * 32'(SrcB);
    case (ALUOp)
      2'b00:   aluOut = SrcA + SrcB;
      2'b01:   aluOut = SrcA - SrcB;
      2'b10:   aluOut = prod[W-1:0];
      default: aluOut = SrcA - SrcB;
    endcase
  end

  alu_arbiter #(.WIDTH(W), .RR_INIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .op0        (op0),
    .op1        (op1),
    .a0         (a0),
    .a1         (a1),
    .b0         (b0),
    .b1         (b1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .result     (result),
    .ltFlag     (ltFlag),
    .ltClear    (ltClear),
    .ALUOp      (ALUOp),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ltRegReset (ltRegReset),
    .aluOut     (aluOut)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b%b exp=00", gnt0, gnt1); end
    n_checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b%b exp=00", done0, done1); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", result); end
    n_checks++; if (ltFlag !== 1'b0) begin n_fail++; $display("FAIL reset_ltflag got=%b exp=0", ltFlag); end
    n_checks++; if (ALUOp !== 2'b00 || SrcA !== 16'h0 || SrcB !== 16'h0) begin n_fail++; $display("FAIL reset_alu_in got=%b/%h/%h exp=00/0000/0000", ALUOp, SrcA, SrcB); end
    n_checks++; if (ltRegReset !== 1'b1) begin n_fail++; $display("FAIL reset_ltregreset got=%b exp=1", ltRegReset); end
    step();
    reset = 1'b0;
    #1;
    n_checks++; if (ltRegReset !== 1'b0) begin n_fail++; $display("FAIL reset_release_ltregreset got=%b exp=0", ltRegReset); end
    $display("txn reset: done");
  endtask

  task automatic test_add();
    op0 = 2'b00; a0 = 16'd3; b0 = 16'd4; req0 = 1'b1;
    step();
    n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL add_gnt got=%b%b exp=10 (gnt0,gnt1)", gnt0, gnt1); end
    n_checks++; if (ALUOp !== 2'b00 || SrcA !== 16'd3 || SrcB !== 16'd4) begin n_fail++; $display("FAIL add_alu_in got=%b/%h/%h exp=00/0003/0004", ALUOp, SrcA, SrcB); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL add_early_done got=%b exp=0", done0); end
    // Operand change after grant must not disturb the transaction.
    a0 = 16'd100;
    step();
    n_checks++; if (done0 !== 1'b1 || done1 !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL add_done got=done%b%b gnt0=%b exp=done10 gnt0=0", done0, done1, gnt0); end
    n_checks++; if (result !== 16'd7) begin n_fail++; $display("FAIL add_result got=%h exp=0007", result); end
    n_checks++; if (ltFlag !== 1'b0) begin n_fail++; $display("FAIL add_ltflag got=%b exp=0", ltFlag); end
    req0 = 1'b0;
    step();
    n_checks++; if (done0 !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL add_idle got=done0=%b gnt0=%b exp=0/0", done0, gnt0); end
    $display("txn add: result=%h", result);
  endtask

  task automatic test_round_robin();
    logic exp1;
    apply_reset();
    op0 = 2'b00; a0 = 16'd10; b0 = 16'd5;
    op1 = 2'b01; a1 = 16'd10; b1 = 16'd3;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp1 = (k % 2 == 1);
      step();
      n_checks++; if (gnt0 !== ~exp1 || gnt1 !== exp1) begin n_fail++; $display("FAIL rr_gnt[%0d] got=%b%b exp=%b%b", k, gnt0, gnt1, ~exp1, exp1); end
      step();
      n_checks++; if (done0 !== ~exp1 || done1 !== exp1) begin n_fail++; $display("FAIL rr_done[%0d] got=%b%b exp=%b%b", k, done0, done1, ~exp1, exp1); end
      n_checks++; if (result !== (exp1 ? 16'd7 : 16'd15)) begin n_fail++; $display("FAIL rr_result[%0d] got=%h exp=%h", k, result, exp1 ? 16'd7 : 16'd15); end
      $display("txn rr[%0d]: owner=%0d result=%h", k, exp1, result);
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      step();
    end
    n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL rr_quiet got=%b%b exp=00", gnt0, gnt1); end
  endtask

  task automatic test_compare();
    op1 = 2'b11; a1 = 16'h0002; b1 = 16'h0005; req1 = 1'b1;
    step();
    n_checks++; if (gnt1 !== 1'b1 || ALUOp !== 2'b11) begin n_fail++; $display("FAIL cmp_gnt got=gnt1=%b op=%b exp=1/11", gnt1, ALUOp); end
    step();
    n_checks++; if (done1 !== 1'b1 || result !== 16'hFFFD) begin n_fail++; $display("FAIL cmp_lt_result got=done1=%b %h exp=1 FFFD", done1, result); end
    n_checks++; if (ltFlag !== 1'b1) begin n_fail++; $display("FAIL cmp_lt_flag got=%b exp=1", ltFlag); end
    req1 = 1'b0;
    step();
    n_checks++; if (ALUOp !== 2'b00) begin n_fail++; $display("FAIL cmp_aluop_idle got=%b exp=00", ALUOp); end
    $display("txn cmp 2<5: result=%h ltFlag=%b", result, ltFlag);
    a1 = 16'd5; b1 = 16'd2; req1 = 1'b1;
    step();
    step();
    n_checks++; if (result !== 16'd3 || ltFlag !== 1'b0) begin n_fail++; $display("FAIL cmp_ge got=%h lt=%b exp=0003 lt=0", result, ltFlag); end
    req1 = 1'b0;
    step();
    $display("txn cmp 5<2: result=%h ltFlag=%b", result, ltFlag);
  endtask

  task automatic test_wrap();
    op0 = 2'b10; a0 = 16'h0100; b0 = 16'h0100; req0 = 1'b1;
    step();
    step();
    n_checks++; if (done0 !== 1'b1 || result !== 16'h0000) begin n_fail++; $display("FAIL mul_wrap got=done0=%b %h exp=1 0000", done0, result); end
    req0 = 1'b0;
    step();
    $display("txn mul wrap: result=%h", result);
    op0 = 2'b00; a0 = 16'hFFFF; b0 = 16'h0001; req0 = 1'b1;
    step();
    step();
    n_checks++; if (done0 !== 1'b1 || result !== 16'h0000) begin n_fail++; $display("FAIL add_wrap got=done0=%b %h exp=1 0000", done0, result); end
    req0 = 1'b0;
    step();
    $display("txn add wrap: result=%h", result);
  endtask

  task automatic test_lt_clear_exec();
    op0 = 2'b11; a0 = 16'd2; b0 = 16'd5; req0 = 1'b1;
    step();
    step();
    n_checks++; if (ltFlag !== 1'b1) begin n_fail++; $display("FAIL clr_setup_lt got=%b exp=1", ltFlag); end
    req0 = 1'b0;
    step();
    op0 = 2'b00; a0 = 16'd1; b0 = 16'd1; req0 = 1'b1;
    step();
    ltClear = 1'b1;
    #1;
    n_checks++; if (ltRegReset !== 1'b0) begin n_fail++; $display("FAIL clr_exec_ltregreset got=%b exp=0", ltRegReset); end
    step();
    ltClear = 1'b0;
    #1;
    n_checks++; if (ltFlag !== 1'b1) begin n_fail++; $display("FAIL clr_exec_lt_held got=%b exp=1", ltFlag); end
    n_checks++; if (ltRegReset !== 1'b1) begin n_fail++; $display("FAIL clr_done_ltregreset got=%b exp=1", ltRegReset); end
    req0 = 1'b0;
    step();
    n_checks++; if (ltFlag !== 1'b0 || result !== 16'd2) begin n_fail++; $display("FAIL clr_after_done got=lt=%b %h exp=lt=0 0002", ltFlag, result); end
    n_checks++; if (ltRegReset !== 1'b0) begin n_fail++; $display("FAIL clr_pending_cleared got=%b exp=0", ltRegReset); end
    $display("txn deferred clear: ltFlag=%b", ltFlag);
  endtask

  task automatic test_reset_mid();
    op0 = 2'b00; a0 = 16'd7; b0 = 16'd8; req0 = 1'b1;
    step();
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_gnt got=%b exp=1", gnt0); end
    reset = 1'b1;
    #1;
    n_checks++; if (ltRegReset !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ltregreset got=%b exp=1", ltRegReset); end
    step();
    reset = 1'b0;
    n_checks++; if (done0 !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_abort got=done0=%b gnt0=%b exp=0/0", done0, gnt0); end
    n_checks++; if (result !== 16'h0000 || ALUOp !== 2'b00) begin n_fail++; $display("FAIL rst_mid_state got=%h op=%b exp=0000 op=00", result, ALUOp); end
    op1 = 2'b01; a1 = 16'd10; b1 = 16'd3; req1 = 1'b1;
    step();
    n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_prio got=%b%b exp=10", gnt0, gnt1); end
    step();
    n_checks++; if (done0 !== 1'b1 || result !== 16'd15) begin n_fail++; $display("FAIL rst_mid_result got=done0=%b %h exp=1 000f", done0, result); end
    req0 = 1'b0; req1 = 1'b0;
    step();
    $display("txn reset mid-flight: result=%h", result);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; ltClear = 1'b0;
    op0 = 2'b00; op1 = 2'b00; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    test_reset();
    test_add();
    test_round_robin();
    test_compare();
    test_wrap();
    test_lt_clear_exec();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule
